// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM encoding, frame geometry and default
// parameters used by both directions of the PS/2 link.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StCheck
    } ps2_state_e;

    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam int unsigned PS2_DATA_BITS  = 8;

    localparam int unsigned PS2_FILTER_LEN  = 8;
    localparam int unsigned PS2_FIFO_DEPTH  = 4;
    localparam int unsigned PS2_TIMEOUT_CYC = 20000;

endpackage

// File: rtl/ps2_byte_fifo.sv
// Synchronous show-ahead byte FIFO; head is on dout whenever not empty, 0 otherwise.
// A push while full succeeds only if a pop happens in the same cycle.
module ps2_byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [7:0]    mem_q [DEPTH];
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? 8'h00 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/ps2_rx_framed.sv
// PS/2 device-to-host receiver: clock deglitch, data sync, 11-bit frame check,
// watchdog abort and a byte queue for downstream decoders.
module ps2_rx_framed
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = PS2_FILTER_LEN,
    parameter int unsigned FIFO_DEPTH  = PS2_FIFO_DEPTH,
    parameter int unsigned TIMEOUT_CYC = PS2_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2d,
    input  logic       ps2c,
    input  logic       rx_en,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full,
    output logic       busy,
    output logic       rx_done_tick,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow,
    output logic       timeout_err
);
    localparam int unsigned WdW = $clog2(TIMEOUT_CYC);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYC - 1);

    logic [FILTER_LEN-1:0]       filt_sr_q;
    logic                        filt_q;
    logic                        fall;
    logic                        d_meta_q, d_sync_q;
    ps2_state_e                  state_q;
    logic [PS2_FRAME_BITS-2:0]   frame_q;
    logic [3:0]                  bit_cnt_q;
    logic [WdW-1:0]              wd_q;
    logic                        in_check, stop_ok, par_ok, push;

    // fall fires in the same cycle the filtered clock drops
    assign fall = filt_q & ~|filt_sr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_sr_q <= '1;
            filt_q    <= 1'b1;
            d_meta_q  <= 1'b1;
            d_sync_q  <= 1'b1;
        end else begin
            filt_sr_q <= {filt_sr_q[FILTER_LEN-2:0], ps2c};
            if (&filt_sr_q)       filt_q <= 1'b1;
            else if (~|filt_sr_q) filt_q <= 1'b0;
            d_meta_q <= ps2d;
            d_sync_q <= d_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            frame_q     <= '0;
            bit_cnt_q   <= '0;
            wd_q        <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    wd_q <= '0;
                    if (fall && rx_en && !d_sync_q) begin
                        state_q   <= StData;
                        bit_cnt_q <= 4'(PS2_FRAME_BITS - 2);
                        busy      <= 1'b1;
                    end
                end
                StData: begin
                    if (fall) begin
                        frame_q <= {d_sync_q, frame_q[PS2_FRAME_BITS-2:1]};
                        wd_q    <= '0;
                        if (bit_cnt_q == 4'd0) state_q <= StCheck;
                        else bit_cnt_q <= bit_cnt_q - 4'd1;
                    end else if (wd_q == WdLast) begin
                        timeout_err <= 1'b1;
                        state_q     <= StIdle;
                        busy        <= 1'b0;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                StCheck: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // frame_q = {stop, parity, d7..d0}; outcome is decided in the CHECK cycle so a
    // same-cycle pop can make room for the byte
    assign in_check     = (state_q == StCheck);
    assign stop_ok      = frame_q[PS2_FRAME_BITS-2];
    assign par_ok       = ^frame_q[PS2_DATA_BITS:0];
    assign frame_err    = in_check & ~stop_ok;
    assign parity_err   = in_check & stop_ok & ~par_ok;
    assign overflow     = in_check & stop_ok & par_ok & full & ~rd_en;
    assign push         = in_check & stop_ok & par_ok & (~full | rd_en);
    assign rx_done_tick = push;

    ps2_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (rd_en),
        .din  (frame_q[PS2_DATA_BITS-1:0]),
        .dout (dout),
        .empty(empty),
        .full (full)
    );

endmodule

// File: tb/tb_ps2_rx_framed.sv
// Directed bench for ps2_rx_framed: good/bad frames, FIFO fill/overflow,
// watchdog, glitch rejection and mid-frame reset.
module tb_ps2_rx_framed;
    localparam int unsigned FL = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TO = 200;

    logic       clk = 1'b0;
    logic       reset, ps2d, ps2c, rx_en, rd_en;
    logic [7:0] dout;
    logic       empty, full, busy, rx_done_tick, parity_err, frame_err, overflow, timeout_err;

    int n_cmp = 0, n_err = 0;
    int n_done = 0, n_par = 0, n_frm = 0, n_ovf = 0, n_to = 0, n_multi = 0;

    ps2_rx_framed #(
        .FILTER_LEN (FL),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2d        (ps2d),
        .ps2c        (ps2c),
        .rx_en       (rx_en),
        .rd_en       (rd_en),
        .dout        (dout),
        .empty       (empty),
        .full        (full),
        .busy        (busy),
        .rx_done_tick(rx_done_tick),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) begin
            if (rx_done_tick) n_done++;
            if (parity_err)   n_par++;
            if (frame_err)    n_frm++;
            if (overflow)     n_ovf++;
            if (timeout_err)  n_to++;
            if (int'(rx_done_tick) + int'(parity_err) + int'(frame_err) + int'(overflow)
                + int'(timeout_err) > 1) n_multi++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required $finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // bits[0] goes out first; optionally pops during the CHECK cycle of the last bit
    task automatic send_bits(input logic [10:0] bits, input int n, input bit pop_at_check);
        for (int i = 0; i < n; i++) begin
            ps2d = bits[i];
            repeat (4) @(negedge clk);
            ps2c = 1'b0;
            if (pop_at_check && i == n - 1) begin
                repeat (FL + 1) @(negedge clk);
                rd_en = 1'b1;
                #1;
                check("check_pop_done", rx_done_tick, 1);
                check("check_pop_ovf", overflow, 0);
                @(negedge clk);
                rd_en = 1'b0;
                repeat (4) @(negedge clk);
            end else begin
                repeat (10) @(negedge clk);
            end
            ps2c = 1'b1;
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par_flip, input logic stop,
                              input bit pop_at_check);
        logic par;
        par = (~^data) ^ par_flip;
        send_bits({stop, par, data, 1'b0}, 11, pop_at_check);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check({tag, "_dout"}, dout, exp);
        check({tag, "_empty"}, empty, 0);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1; rd_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {rx_done_tick, parity_err, frame_err, overflow, timeout_err}, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // good byte, then pop
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check("t1_done", n_done, 1);
        check("t1_errs", n_par + n_frm + n_ovf + n_to, 0);
        pop_expect("t1_head", 8'h1C);
        check("t1_empty_after_pop", empty, 1);
        check("t1_dout_after_pop", dout, 0);

        // parity error, then stop-bit error
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        check("t2_par", n_par, 1);
        check("t2_empty", empty, 1);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        check("t2_frm", n_frm, 1);
        check("t2_no_push", n_done, 1);
        check("t2_empty2", empty, 1);

        // fill, overflow, drain
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        send_frame(8'h32, 1'b0, 1'b1, 1'b0);
        check("t3_not_full_3", full, 0);
        send_frame(8'h21, 1'b0, 1'b1, 1'b0);
        check("t3_full_4", full, 1);
        send_frame(8'h23, 1'b0, 1'b1, 1'b0);
        check("t3_ovf", n_ovf, 1);
        check("t3_done", n_done, 5);
        pop_expect("t3_r0", 8'hF0);
        pop_expect("t3_r1", 8'h1C);
        pop_expect("t3_r2", 8'h32);
        pop_expect("t3_r3", 8'h21);
        check("t3_drained", empty, 1);

        // same, but pop during the 5th CHECK cycle
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        send_frame(8'h32, 1'b0, 1'b1, 1'b0);
        send_frame(8'h21, 1'b0, 1'b1, 1'b0);
        send_frame(8'h23, 1'b0, 1'b1, 1'b1);
        check("t3b_ovf", n_ovf, 1);
        check("t3b_done", n_done, 10);
        check("t3b_full", full, 1);
        pop_expect("t3b_r0", 8'h1C);
        pop_expect("t3b_r1", 8'h32);
        pop_expect("t3b_r2", 8'h21);
        pop_expect("t3b_r3", 8'h23);
        check("t3b_drained", empty, 1);

        // start + 3 data bits, then silence until the watchdog fires
        send_bits(11'b000_0000_1010, 4, 1'b0);
        check("t4_busy_mid", busy, 1);
        for (int k = 0; k < 2 * TO && n_to == 0; k++) @(negedge clk);
        check("t4_timeout", n_to, 1);
        check("t4_busy", busy, 0);
        check("t4_no_push", empty, 1);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        check("t4_done", n_done, 11);
        pop_expect("t4_head", 8'h5A);

        // short clock glitches, then a whole frame with rx_en low
        for (int g = 0; g < 3; g++) begin
            ps2c = 1'b0;
            repeat (FL - 1) @(negedge clk);
            ps2c = 1'b1;
            repeat (FL + 2) @(negedge clk);
            check("t5_glitch_busy", busy, 0);
        end
        rx_en = 1'b0;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check("t5_busy", busy, 0);
        check("t5_empty", empty, 1);
        check("t5_done", n_done, 11);
        check("t5_errs", n_par + n_frm + n_ovf + n_to, 4);
        rx_en = 1'b1;

        // two bytes queued, reset after the 5th bit of a third frame
        send_frame(8'h32, 1'b0, 1'b1, 1'b0);
        send_frame(8'h21, 1'b0, 1'b1, 1'b0);
        check("t6_queued", n_done, 13);
        send_bits(11'b101_0101_0100, 5, 1'b0);
        check("t6_busy_mid", busy, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("t6_empty", empty, 1);
        check("t6_busy", busy, 0);
        check("t6_dout", dout, 0);
        repeat (3) @(negedge clk);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check("t6_done", n_done, 14);
        pop_expect("t6_head", 8'h1C);
        check("t6_drained", empty, 1);

        check("final_par", n_par, 1);
        check("final_frm", n_frm, 1);
        check("final_ovf", n_ovf, 1);
        check("final_to", n_to, 1);
        check("final_exclusive", n_multi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
